oaer_arb: RTL and testbench
===========================

# oaer_arb

Two-input arbiter that shares the single 32-bit AER output port between two event sources: the SpiNNaker-to-AER mapper stream (port 0) and a secondary event stream (port 1, e.g. loopback or test generator). It sits between those sources and the off-chip AER output driver. It provides:
- round-robin arbitration with a bounded burst length;
- a registered output stage;
- per-source saturating event counters for status readback.

## Interface
Parameters:
- DATA_WIDTH, 32: event width on all data ports.
- MAX_BURST, 4: maximum consecutive grants to one source while the other source is requesting. Legal range 1..15.
- CNT_WIDTH, 16: width of each event counter.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  1 = accept new events; 0 = stop accepting, output stage still drains.
- req0_data  in  DATA_WIDTH  event from source 0.
- req0_vld  in  1  source 0 event valid.
- req0_rdy  out  1  source 0 event accepted this cycle when high with req0_vld.
- req1_data  in  DATA_WIDTH  event from source 1.
- req1_vld  in  1  source 1 event valid.
- req1_rdy  out  1  source 1 event accepted this cycle when high with req1_vld.
- oaer_data  out  DATA_WIDTH  registered output event.
- oaer_vld  out  1  output event valid.
- oaer_rdy  in  1  AER driver ready.
- owner  out  2  current FSM state: 00 IDLE, 01 OWN0, 10 OWN1.
- evt_cnt0  out  CNT_WIDTH  events accepted from source 0, saturating.
- evt_cnt1  out  CNT_WIDTH  events accepted from source 1, saturating.

## Operation
- **Output stage.** One-entry register holding oaer_data and oaer_vld.
  - load_ok = enable & ~rst & (~oaer_vld | oaer_rdy).
- **Ready and accept.**
  - reqN_rdy = load_ok & (sel == N). Both are combinational and at most one is high.
  - Selection depends on req0_vld, req1_vld, state and burst_cnt. Sources must not make vld depend on rdy.
  - accept = reqN_vld & reqN_rdy.
  - On accept: oaer_data <= reqN_data and oaer_vld <= 1.
  - Output drain with no accept in the same cycle: oaer_vld <= 0. oaer_data holds its value.
- **FSM.** States are IDLE, OWN0 and OWN1. burst_cnt is 4 bits.
  - IDLE:
    - req0_vld wins, including when both are valid: go to OWN0, burst_cnt = 1.
    - Else req1_vld: go to OWN1, burst_cnt = 1.
  - OWNn, other source not valid:
    - Keep granting n.
    - burst_cnt increments and saturates at MAX_BURST.
  - OWNn, other source valid:
    - If burst_cnt < MAX_BURST and reqn_vld: grant n, burst_cnt + 1.
    - Otherwise grant the other source: move to OWNother, burst_cnt = 1.
  - OWNn, neither source valid: stay in OWNn, burst_cnt unchanged.
  - State and burst_cnt change only on accept cycles, plus the enable rule below.
  - enable = 0: next state IDLE, burst_cnt = 0.
- **Counters.**
  - evt_cntN increments on each accept from source N.
  - Saturates at 2^CNT_WIDTH−1 and never wraps.
- **Reset values:**
  - oaer_vld = 0, oaer_data = 0.
  - owner = 00 (IDLE), burst_cnt = 0.
  - evt_cnt0 = evt_cnt1 = 0.
  - req0_rdy = req1_rdy = 0 while rst is high.
  - Reset mid-operation discards the event held in the output register without presenting it.

## Timing
- Latency: accept in cycle T, so oaer_vld = 1 with that data from cycle T+1.
- Throughput: one event per cycle while oaer_rdy is held high.
- Back-pressure:
  - oaer_vld = 1 and oaer_rdy = 0 gives both rdy = 0.
  - oaer_data and oaer_vld stay stable until the drain.
- Simultaneous drain and accept: the new event replaces the old one in the same edge, with no bubble.
- enable falling:
  - Takes effect in the same cycle: rdy = 0.
  - A held output event still drains.
  - FSM is in IDLE from the next edge.
- Both sources continuously valid with oaer_rdy = 1:
  - Grant pattern is MAX_BURST×src0 then MAX_BURST×src1, repeating, starting with src0 out of IDLE.

## Test plan
1. **Reset and single stream.**
   - Stimulus: assert rst for 2 cycles; check all outputs at reset values. Release; drive req0 with 0x00000001..0x00000005 and oaer_rdy = 1.
   - Required: oaer_data shows the same sequence one cycle after each accept, no gaps; evt_cnt0 = 5; owner = 01.
2. **Fair burst, MAX_BURST = 4.**
   - Stimulus: both sources continuously valid for 16 accepts; src0 data 0xA000000k, src1 data 0xB000000k.
   - Required: output order A0..A3, B0..B3, A4..A7, B4..B7; evt_cnt0 = evt_cnt1 = 8.
3. **Back-pressure.**
   - Stimulus: hold oaer_rdy = 0 for 5 cycles with both sources valid.
   - Required: exactly one event is loaded; then req0_rdy = req1_rdy = 0 and oaer_data stays stable. On oaer_rdy = 1, drain and reload happen in the same cycle.
4. **Enable gating.**
   - Stimulus: deassert enable while an event is held and oaer_rdy = 0; then raise oaer_rdy.
   - Required: the held event drains; no new accepts; owner = 00. Re-enable with both sources valid: src0 wins.
5. **Counter saturation and reset mid-burst.**
   - Stimulus: CNT_WIDTH = 4; accept 20 events from src1.
   - Required: evt_cnt1 = 15 and holds there.
   - Stimulus: assert rst while oaer_vld = 1.
   - Required: oaer_vld = 0 the next cycle; counters = 0; the discarded event never appears.

Source files
------------

// File: rtl/oaer_arb.sv
// oaer_arb: two-source round-robin arbiter feeding the shared AER output port.
// Source 0 is the mapper stream, source 1 the secondary (loopback/test) stream.
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   enable                1 = accept new events; 0 = stop accepting, output still drains
//   req0_*/req1_*         valid/ready event inputs (rdy is combinational)
//   oaer_data/vld/rdy     registered one-entry output stage towards the AER driver
//   owner                 current arbitration state (00 IDLE, 01 OWN0, 10 OWN1)
//   evt_cnt0/evt_cnt1     saturating per-source accept counters
module oaer_arb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_vld,
  output logic                  req0_rdy,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_vld,
  output logic                  req1_rdy,
  output logic [DATA_WIDTH-1:0] oaer_data,
  output logic                  oaer_vld,
  input  logic                  oaer_rdy,
  output logic [1:0]            owner,
  output logic [CNT_WIDTH-1:0]  evt_cnt0,
  output logic [CNT_WIDTH-1:0]  evt_cnt1
);

  localparam int unsigned BURST_W = 4;
  localparam logic [BURST_W-1:0] LP_MAX = BURST_W'(MAX_BURST);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BURST_W-1:0]    r_burst;
  logic [BURST_W-1:0]    w_burst_nxt;
  logic                  w_sel;
  logic                  w_load_ok;
  logic                  w_acc;
  logic                  w_same_src;
  logic [DATA_WIDTH-1:0] r_oaer_data;
  logic                  r_oaer_vld;
  logic [CNT_WIDTH-1:0]  r_cnt0;
  logic [CNT_WIDTH-1:0]  r_cnt1;

  // Selection, handshake and next-state logic
  always_comb begin
    w_sel       = 1'b0;
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    w_same_src  = 1'b0;
    w_load_ok   = enable & ~rst & (~r_oaer_vld | oaer_rdy);

    case (r_state)
      ST_IDLE: w_sel = ~req0_vld & req1_vld;
      // Leave source 0 only when source 1 waits and 0 cannot extend its burst
      ST_OWN0: w_sel = req1_vld & ~(req0_vld & (r_burst < LP_MAX));
      // Mirror of OWN0: stay on 1 unless 0 waits and 1 cannot extend its burst
      ST_OWN1: w_sel = ~(req0_vld & ~(req1_vld & (r_burst < LP_MAX)));
      default: w_sel = 1'b0;
    endcase

    req0_rdy = w_load_ok & ~w_sel;
    req1_rdy = w_load_ok & w_sel;
    w_acc    = (req0_vld & req0_rdy) | (req1_vld & req1_rdy);

    w_same_src = ((r_state == ST_OWN0) & ~w_sel) | ((r_state == ST_OWN1) & w_sel);

    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_burst_nxt = '0;
    end else if (w_acc) begin
      if (w_same_src) begin
        w_burst_nxt = (r_burst >= LP_MAX) ? LP_MAX : r_burst + BURST_W'(1);
      end else begin
        w_state_nxt = w_sel ? ST_OWN1 : ST_OWN0;
        w_burst_nxt = BURST_W'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_burst <= w_burst_nxt;
    end
  end

  // Output stage: accept replaces the held event, otherwise a drain empties it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_oaer_data <= '0;
      r_oaer_vld  <= 1'b0;
    end else if (w_acc) begin
      r_oaer_data <= w_sel ? req1_data : req0_data;
      r_oaer_vld  <= 1'b1;
    end else if (oaer_rdy) begin
      r_oaer_vld  <= 1'b0;
    end
  end

  // Saturating per-source accept counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (req0_vld && req0_rdy && (r_cnt0 != {CNT_WIDTH{1'b1}})) begin
        r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
      end
      if (req1_vld && req1_rdy && (r_cnt1 != {CNT_WIDTH{1'b1}})) begin
        r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
      end
    end
  end

  assign oaer_data = r_oaer_data;
  assign oaer_vld  = r_oaer_vld;
  assign owner     = r_state;
  assign evt_cnt0  = r_cnt0;
  assign evt_cnt1  = r_cnt1;

endmodule

// File: tb/tb_oaer_arb.sv
// tb_oaer_arb: self-checking bench for oaer_arb (MAX_BURST=4, CNT_WIDTH=4).
// Output events are checked through a scoreboard queue filled from expected
// accepts; back-pressure/enable corners use a per-cycle vector table.
module tb_oaer_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [31:0] req0_data;
  logic        req0_vld;
  logic        req0_rdy;
  logic [31:0] req1_data;
  logic        req1_vld;
  logic        req1_rdy;
  logic [31:0] oaer_data;
  logic        oaer_vld;
  logic        oaer_rdy;
  logic [1:0]  owner;
  logic [3:0]  evt_cnt0;
  logic [3:0]  evt_cnt1;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  typedef struct packed {
    logic       en;
    logic       v0;
    logic       v1;
    logic       ordy;
    logic       r0;
    logic       r1;
    logic       vld;
    logic [1:0] own;
  } vec_t;

  vec_t vt [19];

  oaer_arb #(.DATA_WIDTH(32), .MAX_BURST(4), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .req0_data(req0_data), .req0_vld(req0_vld), .req0_rdy(req0_rdy),
    .req1_data(req1_data), .req1_vld(req1_vld), .req1_rdy(req1_rdy),
    .oaer_data(oaer_data), .oaer_vld(oaer_vld), .oaer_rdy(oaer_rdy),
    .owner(owner), .evt_cnt0(evt_cnt0), .evt_cnt1(evt_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare a draining output event against the oldest expected one
  task automatic sb_drain();
    logic [31:0] e;
    if (oaer_vld && oaer_rdy) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_empty: got %h expected no event", oaer_data);
      end else begin
        e = sb_q.pop_front();
        chk("sb_data", oaer_data, e);
      end
    end
  endtask

  task automatic drive(input logic en_i, input logic v0_i, input logic [31:0] d0_i,
                       input logic v1_i, input logic [31:0] d1_i, input logic ordy_i);
    @(negedge clk);
    enable    = en_i;
    req0_vld  = v0_i;
    req0_data = d0_i;
    req1_vld  = v1_i;
    req1_data = d1_i;
    oaer_rdy  = ordy_i;
    #1;
    sb_drain();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b1; req0_vld = 1'b1; req1_vld = 1'b1; oaer_rdy = 1'b1;
    req0_data = 32'h1111_1111; req1_data = 32'h2222_2222;
    sb_q.delete();
    #1;
    chk("rst_rdy0", 32'(req0_rdy), 32'd0);
    chk("rst_rdy1", 32'(req1_rdy), 32'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_vld", 32'(oaer_vld), 32'd0);
    chk("rst_data", oaer_data, 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_cnt0", 32'(evt_cnt0), 32'd0);
    chk("rst_cnt1", 32'(evt_cnt1), 32'd0);
    chk("rst_rdy0_held", 32'(req0_rdy), 32'd0);
    rst = 1'b0; req0_vld = 1'b0; req1_vld = 1'b0;
  endtask

  initial begin
    int k0;
    int k1;
    int acc;
    int blk;
    vec_t v;

    // en v0 v1 ordy | rdy0 rdy1 vld | owner
    vt[0]  = vec_t'(9'b1110_100_00);
    vt[1]  = vec_t'(9'b1110_001_01);
    vt[2]  = vec_t'(9'b1110_001_01);
    vt[3]  = vec_t'(9'b1110_001_01);
    vt[4]  = vec_t'(9'b1110_001_01);
    vt[5]  = vec_t'(9'b1111_101_01);
    vt[6]  = vec_t'(9'b1111_101_01);
    vt[7]  = vec_t'(9'b1111_101_01);
    vt[8]  = vec_t'(9'b1111_011_01);
    vt[9]  = vec_t'(9'b1111_011_10);
    vt[10] = vec_t'(9'b1110_001_10);
    vt[11] = vec_t'(9'b0110_001_10);
    vt[12] = vec_t'(9'b0111_001_00);
    vt[13] = vec_t'(9'b0111_000_00);
    vt[14] = vec_t'(9'b1111_100_00);
    vt[15] = vec_t'(9'b1001_101_01);
    vt[16] = vec_t'(9'b1011_010_01);
    vt[17] = vec_t'(9'b1001_011_10);
    vt[18] = vec_t'(9'b1001_010_10);

    rst = 1'b1; enable = 1'b0; req0_vld = 1'b0; req1_vld = 1'b0; oaer_rdy = 1'b0;
    req0_data = '0; req1_data = '0;

    // Reset and single stream from source 0
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 1'b1, 32'(i), 1'b0, 32'h0, 1'b1);
      chk("t1_rdy0", 32'(req0_rdy), 32'd1);
      if (i > 1) chk("t1_nogap", 32'(oaer_vld), 32'd1);
      sb_q.push_back(32'(i));
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("t1_vld_last", 32'(oaer_vld), 32'd1);
    chk("t1_cnt0", 32'(evt_cnt0), 32'd5);
    chk("t1_owner", 32'(owner), 32'd1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("t1_sb_left", 32'(sb_q.size()), 32'd0);

    // Fair burst: both sources always valid
    do_reset();
    for (int j = 0; j < 16; j++) begin
      blk = j / 4;
      if (blk % 2 == 0) sb_q.push_back(32'hA000_0000 + 32'((blk / 2) * 4 + j % 4));
      else              sb_q.push_back(32'hB000_0000 + 32'((blk / 2) * 4 + j % 4));
    end
    k0 = 0; k1 = 0; acc = 0;
    for (int c = 0; c < 40 && acc < 16; c++) begin
      drive(1'b1, 1'b1, 32'hA000_0000 + 32'(k0), 1'b1, 32'hB000_0000 + 32'(k1), 1'b1);
      if (req0_rdy) begin k0++; acc++; end
      if (req1_rdy) begin k1++; acc++; end
    end
    chk("t2_accepts", 32'(acc), 32'd16);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("t2_sb_left", 32'(sb_q.size()), 32'd0);
    chk("t2_cnt0", 32'(evt_cnt0), 32'd8);
    chk("t2_cnt1", 32'(evt_cnt1), 32'd8);

    // Back-pressure, burst hand-over and enable gating
    do_reset();
    k0 = 0; k1 = 0;
    for (int i = 0; i < 19; i++) begin
      v = vt[i];
      drive(v.en, v.v0, 32'hC000_0000 + 32'(k0), v.v1, 32'hD000_0000 + 32'(k1), v.ordy);
      chk($sformatf("v%0d_rdy0", i), 32'(req0_rdy), 32'(v.r0));
      chk($sformatf("v%0d_rdy1", i), 32'(req1_rdy), 32'(v.r1));
      chk($sformatf("v%0d_vld", i), 32'(oaer_vld), 32'(v.vld));
      chk($sformatf("v%0d_owner", i), 32'(owner), 32'(v.own));
      if (i >= 1 && i <= 4) chk($sformatf("v%0d_hold", i), oaer_data, 32'hC000_0000);
      if (v.r0 && v.v0) begin sb_q.push_back(32'hC000_0000 + 32'(k0)); k0++; end
      if (v.r1 && v.v1) begin sb_q.push_back(32'hD000_0000 + 32'(k1)); k1++; end
    end
    chk("t3_sb_left", 32'(sb_q.size()), 32'd0);

    // Counter saturation, then reset while an event is held
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hE000_0000 + 32'(i), 1'b1);
      chk("t5_rdy1", 32'(req1_rdy), 32'd1);
      if (i == 17) chk("t5_cnt1_sat", 32'(evt_cnt1), 32'd15);
      sb_q.push_back(32'hE000_0000 + 32'(i));
    end
    @(negedge clk);
    #1;
    chk("t5_held_vld", 32'(oaer_vld), 32'd1);
    chk("t5_cnt1_hold", 32'(evt_cnt1), 32'd15);
    rst = 1'b1; oaer_rdy = 1'b0; req1_vld = 1'b0;
    sb_q.delete();
    @(negedge clk);
    #1;
    chk("t5_rst_vld", 32'(oaer_vld), 32'd0);
    chk("t5_rst_data", oaer_data, 32'd0);
    chk("t5_rst_cnt0", 32'(evt_cnt0), 32'd0);
    chk("t5_rst_cnt1", 32'(evt_cnt1), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("t5_no_ghost", 32'(oaer_vld), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
